// File: rtl/wb_master_seq.sv
// Wishbone classic-cycle master sequencer.
// Queues read/write commands, runs them one at a time on the bus, and returns
// one response per command. Retries on rty up to MAX_RETRY times and gives up
// on a cycle that stays unterminated for TIMEOUT cycles.
module wb_master_seq #(
  parameter int unsigned AW        = 18,
  parameter int unsigned DW        = 16,
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_we,
  input  logic [AW-1:0]      cmd_adr,
  input  logic [DW-1:0]      cmd_dat,
  input  logic [DW/8-1:0]    cmd_sel,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DW-1:0]      rsp_dat,
  output logic [1:0]         rsp_status,
  output logic               busy,
  output logic               wb_cyc_o,
  output logic               wb_stb_o,
  output logic               wb_we_o,
  output logic [AW-1:0]      wb_adr_o,
  output logic [DW-1:0]      wb_dat_o,
  output logic [DW/8-1:0]    wb_sel_o,
  input  logic [DW-1:0]      wb_dat_i,
  input  logic               wb_ack_i,
  input  logic               wb_err_i,
  input  logic               wb_rty_i
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned PW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam int unsigned RW = $clog2(MAX_RETRY + 2);

  localparam logic [1:0] ST_ACK = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;
  localparam logic [1:0] ST_RTY = 2'b10;
  localparam logic [1:0] ST_TMO = 2'b11;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    BACKOFF = 2'd2,
    RESP    = 2'd3
  } state_t;

  cmd_t          mem [CMD_DEPTH];
  cmd_t          in_cmd;
  cmd_t          head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          push;
  logic          pop;
  logic          empty;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] tmo_cnt;
  logic [TW-1:0] tmo_nxt;
  logic [RW-1:0] retry_cnt;
  logic [RW-1:0] retry_nxt;
  logic          tmo_hit;
  logic          retry_left;

  logic          cyc_nxt;
  logic          stb_nxt;
  logic          we_nxt;
  logic [AW-1:0] adr_nxt;
  logic [DW-1:0] dat_nxt;
  logic [SW-1:0] sel_nxt;
  logic          rsp_valid_nxt;
  logic [DW-1:0] rsp_dat_nxt;
  logic [1:0]    rsp_status_nxt;
  logic          cmd_ready_nxt;
  logic          busy_nxt;

  assign in_cmd     = {cmd_we, cmd_adr, cmd_dat, cmd_sel};
  assign head       = mem[rd_ptr];
  assign push       = cmd_valid & cmd_ready;
  assign empty      = (count == '0);
  assign count_nxt  = count + CW'(push) - CW'(pop);
  assign tmo_hit    = (tmo_cnt == TW'(TIMEOUT - 1));
  assign retry_left = (retry_cnt < RW'(MAX_RETRY));

  // Command FIFO pointers and occupancy
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
    end
  end

  // Command FIFO storage (data only, no reset needed)
  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr] <= in_cmd;
  end

  // FSM state register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = ISSUE;
      ISSUE: begin
        if (wb_ack_i || wb_err_i)  state_nxt = RESP;
        else if (wb_rty_i)         state_nxt = retry_left ? BACKOFF : RESP;
        else if (tmo_hit)          state_nxt = RESP;
      end
      BACKOFF: state_nxt = ISSUE;
      RESP:    if (rsp_valid && rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs, counters and the FIFO pop
  always_comb begin
    pop            = 1'b0;
    cyc_nxt        = wb_cyc_o;
    stb_nxt        = wb_stb_o;
    we_nxt         = wb_we_o;
    adr_nxt        = wb_adr_o;
    dat_nxt        = wb_dat_o;
    sel_nxt        = wb_sel_o;
    rsp_valid_nxt  = rsp_valid;
    rsp_dat_nxt    = rsp_dat;
    rsp_status_nxt = rsp_status;
    tmo_nxt        = tmo_cnt;
    retry_nxt      = retry_cnt;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          cyc_nxt   = 1'b1;
          stb_nxt   = 1'b1;
          we_nxt    = head.we;
          adr_nxt   = head.adr;
          dat_nxt   = head.dat;
          sel_nxt   = head.sel;
          tmo_nxt   = '0;
          retry_nxt = '0;
        end
      end
      ISSUE: begin
        if (wb_ack_i) begin
          cyc_nxt        = 1'b0;
          stb_nxt        = 1'b0;
          rsp_valid_nxt  = 1'b1;
          rsp_dat_nxt    = wb_we_o ? '0 : wb_dat_i;
          rsp_status_nxt = ST_ACK;
        end else if (wb_err_i) begin
          cyc_nxt        = 1'b0;
          stb_nxt        = 1'b0;
          rsp_valid_nxt  = 1'b1;
          rsp_dat_nxt    = '0;
          rsp_status_nxt = ST_ERR;
        end else if (wb_rty_i) begin
          cyc_nxt = 1'b0;
          stb_nxt = 1'b0;
          if (retry_left) begin
            retry_nxt = retry_cnt + RW'(1);
          end else begin
            rsp_valid_nxt  = 1'b1;
            rsp_dat_nxt    = '0;
            rsp_status_nxt = ST_RTY;
          end
        end else if (tmo_hit) begin
          cyc_nxt        = 1'b0;
          stb_nxt        = 1'b0;
          rsp_valid_nxt  = 1'b1;
          rsp_dat_nxt    = '0;
          rsp_status_nxt = ST_TMO;
        end else begin
          tmo_nxt = tmo_cnt + TW'(1);
        end
      end
      BACKOFF: begin
        cyc_nxt = 1'b1;
        stb_nxt = 1'b1;
        tmo_nxt = '0;
      end
      RESP: begin
        if (rsp_ready) rsp_valid_nxt = 1'b0;
      end
      default: ;
    endcase
    cmd_ready_nxt = (count_nxt != CW'(CMD_DEPTH));
    busy_nxt      = (state_nxt != IDLE) || (count_nxt != '0);
  end

  // Output and counter registers; reset drops cyc/stb asynchronously
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_adr_o   <= '0;
      wb_dat_o   <= '0;
      wb_sel_o   <= '0;
      rsp_valid  <= 1'b0;
      rsp_dat    <= '0;
      rsp_status <= '0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      tmo_cnt    <= '0;
      retry_cnt  <= '0;
    end else begin
      wb_cyc_o   <= cyc_nxt;
      wb_stb_o   <= stb_nxt;
      wb_we_o    <= we_nxt;
      wb_adr_o   <= adr_nxt;
      wb_dat_o   <= dat_nxt;
      wb_sel_o   <= sel_nxt;
      rsp_valid  <= rsp_valid_nxt;
      rsp_dat    <= rsp_dat_nxt;
      rsp_status <= rsp_status_nxt;
      cmd_ready  <= cmd_ready_nxt;
      busy       <= busy_nxt;
      tmo_cnt    <= tmo_nxt;
      retry_cnt  <= retry_nxt;
    end
  end

endmodule

// File: tb/tb_wb_master_seq.sv
// Testbench for wb_master_seq: scripted Wishbone slave plus a reference model
// that predicts each response from the slave's per-attempt behaviour.
module tb_wb_master_seq;

  localparam int unsigned AW        = 18;
  localparam int unsigned DW        = 16;
  localparam int unsigned SW        = 2;
  localparam int unsigned TIMEOUT   = 64;
  localparam int unsigned MAX_RETRY = 3;

  localparam int K_NONE = 0;
  localparam int K_ACK  = 1;
  localparam int K_ERR  = 2;
  localparam int K_RTY  = 3;
  localparam int K_AE   = 4;

  logic          wb_clk_i  = 1'b0;
  logic          wb_rst_i  = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_we    = 1'b0;
  logic [AW-1:0] cmd_adr   = '0;
  logic [DW-1:0] cmd_dat   = '0;
  logic [SW-1:0] cmd_sel   = '0;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] wb_dat_i  = '0;
  logic          wb_ack_i  = 1'b0;
  logic          wb_err_i  = 1'b0;
  logic          wb_rty_i  = 1'b0;

  logic          cmd_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_dat;
  logic [1:0]    rsp_status;
  logic          busy;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [SW-1:0] wb_sel_o;

  wb_master_seq #(
    .AW(AW), .DW(DW), .CMD_DEPTH(4), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_status(rsp_status), .busy(busy),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_rty_i(wb_rty_i)
  );

  initial forever #5 wb_clk_i = ~wb_clk_i;

  int cyc_n = 0;
  always @(posedge wb_clk_i) cyc_n <= cyc_n + 1;

  int tests = 0;
  int fails = 0;

  // Slave script: one entry per bus attempt (main writes, slave reads)
  int            scr_kind [0:1023];
  int            scr_lat  [0:1023];
  logic [DW-1:0] scr_dat  [0:1023];
  int            scr_wr   = 0;
  int            scr_rd   = 0;
  int            scr_mark = 0;

  // Slave observations
  int            pulses     = 0;
  int            rise_cycle = 0;
  int            fall_cycle = 0;
  int            cyc_len    = 0;
  int            unstable   = 0;
  int            gap_log [0:1023];
  logic          cap_we;
  logic [AW-1:0] cap_adr;
  logic [DW-1:0] cap_dat;
  logic [SW-1:0] cap_sel;

  typedef struct {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdat;
    logic [SW-1:0] sel;
    logic [DW-1:0] dat;
    logic [1:0]    st;
    int            n;
  } exp_t;
  exp_t exp_q [$];

  int p_mark     = 0;
  int seen_cycle = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scripted slave: drives a termination on the lat-th cycle of each attempt
  initial begin : slave
    int age;
    int cur_kind;
    int cur_lat;
    logic [DW-1:0] cur_dat;
    age = 0; cur_kind = K_NONE; cur_lat = 1; cur_dat = '0;
    forever begin
      @(negedge wb_clk_i);
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_rty_i = 1'b0;
      wb_dat_i = DW'($urandom);
      if (wb_cyc_o && wb_stb_o) begin
        if (age == 0) begin
          pulses++;
          rise_cycle = cyc_n;
          gap_log[pulses % 1024] = cyc_n - fall_cycle;
          cap_we = wb_we_o; cap_adr = wb_adr_o; cap_dat = wb_dat_o; cap_sel = wb_sel_o;
          if (scr_rd < scr_wr) begin
            cur_kind = scr_kind[scr_rd]; cur_lat = scr_lat[scr_rd]; cur_dat = scr_dat[scr_rd];
            scr_rd++;
          end else begin
            cur_kind = K_NONE; cur_lat = 1; cur_dat = '0;
          end
        end else if ({wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o} !== {cap_we, cap_adr, cap_dat, cap_sel}) begin
          unstable++;
        end
        age++;
        cyc_len = age;
        if (age == cur_lat) begin
          case (cur_kind)
            K_ACK: begin wb_ack_i = 1'b1; wb_dat_i = cur_dat; end
            K_ERR: wb_err_i = 1'b1;
            K_RTY: wb_rty_i = 1'b1;
            K_AE:  begin wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = cur_dat; end
            default: ;
          endcase
        end
      end else begin
        if (age != 0) fall_cycle = cyc_n;
        age = 0;
      end
    end
  end

  // Reference model: walk the attempts of one command from script index s
  function automatic void predict(input int s, input logic we, output logic [DW-1:0] d,
                                  output logic [1:0] st, output int n);
    int retries;
    retries = 0; d = '0; st = 2'b11; n = 0;
    for (int i = 0; i < 8; i++) begin
      n = i + 1;
      if (scr_kind[s+i] == K_ACK || scr_kind[s+i] == K_AE) begin
        st = 2'b00; d = we ? '0 : scr_dat[s+i]; return;
      end else if (scr_kind[s+i] == K_ERR) begin
        st = 2'b01; return;
      end else if (scr_kind[s+i] == K_NONE) begin
        st = 2'b11; return;
      end else if (retries == int'(MAX_RETRY)) begin
        st = 2'b10; return;
      end
      retries++;
    end
  endfunction

  task automatic add_att(input int kind, input int lat, input logic [DW-1:0] d);
    scr_kind[scr_wr] = kind; scr_lat[scr_wr] = lat; scr_dat[scr_wr] = d;
    scr_wr++;
  endtask

  task automatic rand_script();
    for (int a = 0; a <= int'(MAX_RETRY); a++) begin
      int r;
      int k;
      r = int'($urandom % 16);
      k = (r == 0) ? K_NONE : (r < 6) ? K_RTY : (r < 8) ? K_ERR : (r == 8) ? K_AE : K_ACK;
      add_att(k, 1 + int'($urandom % 4), DW'($urandom));
      if (k != K_RTY) break;
    end
  endtask

  task automatic expect_cmd(input logic we, input logic [AW-1:0] adr,
                            input logic [DW-1:0] wdat, input logic [SW-1:0] sel);
    exp_t e;
    e.we = we; e.adr = adr; e.wdat = wdat; e.sel = sel;
    predict(scr_mark, we, e.dat, e.st, e.n);
    scr_mark += e.n;
    exp_q.push_back(e);
  endtask

  // Offer a command from a negedge; return at the negedge after acceptance
  task automatic drive_cmd(input logic we, input logic [AW-1:0] adr,
                           input logic [DW-1:0] wdat, input logic [SW-1:0] sel);
    int w;
    w = 0;
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = wdat; cmd_sel = sel;
    while (!cmd_ready && w < 300) begin @(negedge wb_clk_i); w++; end
    chk("cmd_accept", 32'(cmd_ready), 32'd1);
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    cmd_valid = 1'b0;
  endtask

  task automatic send(input logic we, input logic [AW-1:0] adr,
                      input logic [DW-1:0] wdat, input logic [SW-1:0] sel);
    expect_cmd(we, adr, wdat, sel);
    drive_cmd(we, adr, wdat, sel);
  endtask

  // Wait for a response, check it against the model, then consume it
  task automatic get_rsp(input string tag);
    exp_t e;
    int w;
    int hold;
    w = 0;
    while (!rsp_valid && w < 400) begin @(negedge wb_clk_i); w++; end
    seen_cycle = cyc_n;
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    e = exp_q.pop_front();
    chk({tag, "_dat"}, 32'(rsp_dat), 32'(e.dat));
    chk({tag, "_status"}, 32'(rsp_status), 32'(e.st));
    chk({tag, "_attempts"}, 32'(pulses - p_mark), 32'(e.n));
    chk({tag, "_bus"}, {13'd0, cap_we, cap_adr}, {13'd0, e.we, e.adr});
    chk({tag, "_sel"}, 32'(cap_sel), 32'(e.sel));
    chk({tag, "_wdat"}, e.we ? 32'(cap_dat) : 32'd0, e.we ? 32'(e.wdat) : 32'd0);
    hold = 1 + int'($urandom % 3);
    repeat (hold) @(negedge wb_clk_i);
    chk({tag, "_hold"}, {13'd0, rsp_valid, rsp_status, rsp_dat}, {13'd0, 1'b1, e.st, e.dat});
    rsp_ready = 1'b1;
    @(negedge wb_clk_i);
    rsp_ready = 1'b0;
    chk({tag, "_drop"}, 32'(rsp_valid), 32'd0);
    p_mark = pulses;
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int p0;
    int w;
    int bad;
    repeat (3) @(negedge wb_clk_i);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_bus", {27'd0, wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid, busy}, 32'd0);
    chk("rst_rsp", {14'd0, rsp_status, rsp_dat}, 32'd0);
    chk("rst_adr", 32'(wb_adr_o), 32'd0);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    chk("idle_busy", 32'(busy), 32'd0);

    // Read with ack one cycle after stb rises
    add_att(K_ACK, 2, 16'hBEEF);
    expect_cmd(1'b0, 18'h02000, 16'h0000, 2'b11);
    drive_cmd(1'b0, 18'h02000, 16'h0000, 2'b11);
    chk("t1_cyc_not_yet", 32'(wb_cyc_o), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    @(negedge wb_clk_i);
    chk("t1_cyc_rise", 32'({wb_cyc_o, wb_stb_o}), 32'd3);
    get_rsp("t1");
    chk("t1_cyc_len", 32'(cyc_len), 32'd2);

    // Write with immediate ack
    add_att(K_ACK, 1, 16'h7777);
    send(1'b1, 18'h02005, 16'h1234, 2'b11);
    get_rsp("t2");
    chk("t2_cyc_len", 32'(cyc_len), 32'd1);

    // Unresponsive slave: FIFO fills, sixth command stalls, all time out
    for (int i = 0; i < 5; i++) begin
      add_att(K_NONE, 1, '0);
      send(1'b0, AW'(18'h100 + i), DW'($urandom), 2'b01);
    end
    chk("t3_full", 32'(cmd_ready), 32'd0);
    add_att(K_NONE, 1, '0);
    expect_cmd(1'b1, 18'h00200, 16'hCAFE, 2'b10);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 18'h00200; cmd_dat = 16'hCAFE; cmd_sel = 2'b10;
    repeat (5) @(negedge wb_clk_i);
    chk("t3_stall", 32'(cmd_ready), 32'd0);
    get_rsp("t3_first");
    chk("t3_tmo_time", 32'(seen_cycle - rise_cycle), 32'(TIMEOUT));
    chk("t3_cyc_len", 32'(cyc_len), 32'(TIMEOUT));
    w = 0;
    while (!cmd_ready && w < 20) begin @(negedge wb_clk_i); w++; end
    chk("t3_ready_again", 32'(cmd_ready), 32'd1);
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    cmd_valid = 1'b0;
    repeat (5) get_rsp("t3");

    // Two retries, then ack
    add_att(K_RTY, 1, '0);
    add_att(K_RTY, 2, '0);
    add_att(K_ACK, 3, 16'h00A5);
    send(1'b0, 18'h03000, 16'h0000, 2'b11);
    p0 = p_mark;
    get_rsp("t4");
    chk("t4_gap1", 32'(gap_log[(p0 + 2) % 1024]), 32'd1);
    chk("t4_gap2", 32'(gap_log[(p0 + 3) % 1024]), 32'd1);

    // Retries exhausted, then error without retry, then ack+err together
    for (int i = 0; i < 4; i++) add_att(K_RTY, 1, '0);
    send(1'b0, 18'h03004, 16'h0000, 2'b01);
    get_rsp("t5_rty");
    add_att(K_ERR, 2, '0);
    send(1'b1, 18'h03008, 16'h5555, 2'b11);
    get_rsp("t5_err");
    add_att(K_AE, 1, 16'h5A5A);
    send(1'b0, 18'h0300C, 16'h0000, 2'b10);
    get_rsp("t6");

    // Randomized bursts of queued commands
    for (int b = 0; b < 10; b++) begin
      int k;
      k = 1 + int'($urandom % 3);
      for (int c = 0; c < k; c++) begin
        rand_script();
        send(1'($urandom), AW'($urandom), DW'($urandom), SW'($urandom));
      end
      for (int c = 0; c < k; c++) get_rsp("rnd");
    end
    chk("bus_stable", 32'(unstable), 32'd0);

    // Reset while cyc is high with three commands queued
    for (int i = 0; i < 4; i++) drive_cmd(1'b0, AW'(18'h04000 + i), '0, 2'b11);
    chk("rst_pre_cyc", 32'(wb_cyc_o), 32'd1);
    #2;
    wb_rst_i = 1'b1;
    #1;
    chk("rst_async_cyc", 32'({wb_cyc_o, wb_stb_o}), 32'd0);
    chk("rst_async_ready", 32'(cmd_ready), 32'd1);
    chk("rst_async_rsp", {30'd0, rsp_valid, busy}, 32'd0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    rsp_ready = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge wb_clk_i);
      if (wb_cyc_o || rsp_valid || busy) bad++;
    end
    rsp_ready = 1'b0;
    chk("rst_discard", 32'(bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
